// File: rtl/register_file_2r1w.sv
// register_file_2r1w: DEPTH-entry register bank with one write port and two
// independent registered read ports. Reads are write-first: a read of the
// address being written this cycle returns the new data. An optional
// hardwired-zero entry 0 drops writes and always reads back as zero.
// A read port with its enable low holds its last value, including when the
// entry it last read is rewritten.
module register_file_2r1w #(
  parameter int                      DATA_WIDTH  = 16,
  parameter int                      ADDR_WIDTH  = 3,
  parameter int                      ZERO_REG    = 1,
  parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re_a,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  re_b,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Power-up contents are zero, like the single register this replaces.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] r_rdata_a = '0;
  logic [DATA_WIDTH-1:0] r_rdata_b = '0;

  logic                  w_zero_en;
  logic                  w_wr_eff;
  logic [DATA_WIDTH-1:0] w_val_a;
  logic [DATA_WIDTH-1:0] w_val_b;

  assign w_zero_en = (ZERO_REG != 0);

  // A write is effective unless it targets the hardwired-zero entry.
  assign w_wr_eff = we && !(w_zero_en && (waddr == '0));

  // Resolve the value each read port would capture: zero entry first,
  // then same-cycle write forwarding, then the stored entry.
  always_comb begin
    w_val_a = r_mem[raddr_a];
    if (w_zero_en && (raddr_a == '0)) begin
      w_val_a = '0;
    end else if (w_wr_eff && (waddr == raddr_a)) begin
      w_val_a = wdata;
    end

    w_val_b = r_mem[raddr_b];
    if (w_zero_en && (raddr_b == '0)) begin
      w_val_b = '0;
    end else if (w_wr_eff && (waddr == raddr_b)) begin
      w_val_b = wdata;
    end
  end

  // Storage update: reset loads every entry, otherwise one effective write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= (w_zero_en && (i == 0)) ? '0 : RESET_VALUE;
      end
    end else if (w_wr_eff) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read-port registers: capture on enable, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_a <= RESET_VALUE;
      r_rdata_b <= RESET_VALUE;
    end else begin
      if (re_a) begin
        r_rdata_a <= w_val_a;
      end
      if (re_b) begin
        r_rdata_b <= w_val_b;
      end
    end
  end

  assign rdata_a = r_rdata_a;
  assign rdata_b = r_rdata_b;

endmodule

// File: tb/tb_register_file_2r1w.sv
// tb_register_file_2r1w: drives one ZERO_REG=1 and one ZERO_REG=0 instance
// with the same stimulus and checks both against a bench-side model of the
// register file every cycle, plus literal expectations at key points.
module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic        re_a = 1'b0;
  logic [2:0]  raddr_a = '0;
  logic        re_b = 1'b0;
  logic [2:0]  raddr_b = '0;
  logic [15:0] rdata_a1, rdata_b1, rdata_a0, rdata_b0;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  register_file_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1), .RESET_VALUE(16'h0000)) dut_z1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a1),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b1)
  );

  register_file_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0), .RESET_VALUE(16'h0000)) dut_z0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a0),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b0)
  );

  // ---------------- model ----------------
  logic [15:0] mem1 [8] = '{default: 16'h0};
  logic [15:0] mem0 [8] = '{default: 16'h0};
  logic [15:0] m1_a = 16'h0, m1_b = 16'h0, m0_a = 16'h0, m0_b = 16'h0;

  function automatic logic [15:0] model_read(input bit zr, input logic [15:0] m [8],
                                             input logic [2:0] a);
    if (zr && a == 3'd0) return 16'h0;
    if (we && !(zr && waddr == 3'd0) && waddr == a) return wdata;
    return m[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        mem1[i] = 16'h0;
        mem0[i] = 16'h0;
      end
      m1_a = 16'h0; m1_b = 16'h0; m0_a = 16'h0; m0_b = 16'h0;
    end else begin
      if (re_a) begin
        m1_a = model_read(1'b1, mem1, raddr_a);
        m0_a = model_read(1'b0, mem0, raddr_a);
      end
      if (re_b) begin
        m1_b = model_read(1'b1, mem1, raddr_b);
        m0_b = model_read(1'b0, mem0, raddr_b);
      end
      if (we && waddr != 3'd0) mem1[waddr] = wdata;
      if (we) mem0[waddr] = wdata;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_z1_a", rdata_a1, m1_a);
    chk("model_z1_b", rdata_b1, m1_b);
    chk("model_z0_a", rdata_a0, m0_a);
    chk("model_z0_b", rdata_b0, m0_b);
  end

  // ---------------- driver ----------------
  // Inputs are applied one time unit after a posedge, then one edge is taken.
  task automatic cyc(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                     input logic ea, input logic [2:0] ra,
                     input logic eb, input logic [2:0] rb);
    we = w; waddr = wa; wdata = wd;
    re_a = ea; raddr_a = ra; re_b = eb; raddr_b = rb;
    @(posedge clk);
    #1;
    we = 1'b0; re_a = 1'b0; re_b = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] exp_a;
    #1;
    chk("powerup_z1_a", rdata_a1, 16'h0000);
    chk("powerup_z0_b", rdata_b0, 16'h0000);
    @(posedge clk); #1;

    // Reset discards an in-flight write and both reads.
    cyc(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b0, 3'd0);
    chk("pre_reset_read5", rdata_a0, 16'h1234);
    rst = 1'b1;
    cyc(1'b1, 3'd5, 16'h5555, 1'b1, 3'd5, 1'b1, 3'd5);
    rst = 1'b0;
    chk("reset_z1_a", rdata_a1, 16'h0000);
    chk("reset_z0_a", rdata_a0, 16'h0000);
    chk("reset_z0_b", rdata_b0, 16'h0000);
    cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b1, 3'd5);
    chk("after_reset_read5_a", rdata_a0, 16'h0000);
    chk("after_reset_read5_b", rdata_b1, 16'h0000);

    // Basic write, read and hold.
    cyc(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd0);
    chk("basic_read3", rdata_a1, 16'hBEEF);
    cyc(1'b1, 3'd3, 16'h0001, 1'b0, 3'd3, 1'b0, 3'd0);
    idle();
    chk("hold_after_rewrite", rdata_a1, 16'hBEEF);
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd3);
    chk("read3_new", rdata_b1, 16'h0001);

    // Forwarding on both ports.
    cyc(1'b1, 3'd2, 16'h1111, 1'b0, 3'd0, 1'b0, 3'd0);
    cyc(1'b1, 3'd2, 16'h2222, 1'b1, 3'd2, 1'b1, 3'd2);
    chk("fwd_a", rdata_a1, 16'h2222);
    chk("fwd_b", rdata_b1, 16'h2222);
    chk("fwd_z0_a", rdata_a0, 16'h2222);

    // Zero register behaviour, both variants.
    cyc(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b0, 3'd0);
    chk("zero_same_cycle_z1", rdata_a1, 16'h0000);
    chk("zero_same_cycle_z0", rdata_a0, 16'hFFFF);
    cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 1'b1, 3'd0);
    chk("zero_later_z1", rdata_b1, 16'h0000);
    chk("zero_later_z0", rdata_b0, 16'hFFFF);

    // Sweep: fill all entries, then read A ascending / B descending.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'(i), 16'hA000 + 16'(i), 1'b0, 3'd0, 1'b0, 3'd0);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(7 - i));
      exp_a = (i == 0) ? 16'h0000 : 16'hA000 + 16'(i);
      chk("sweep_z1_a", rdata_a1, exp_a);
      chk("sweep_z0_a", rdata_a0, 16'hA000 + 16'(i));
      chk("sweep_z0_b", rdata_b0, 16'hA000 + 16'(7 - i));
    end

    // Mixed traffic checked by the model every cycle.
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      rst = 1'b0;
    end

    idle();
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Parametrised successor of the team's single 16-bit enabled register: a bank of DEPTH registers with one write port and two independent registered read ports.
- Sits in the datapath as the architectural register file feeding the ALU operand latches.
- Adds over the single register:
  - addressing
  - an optional hardwired-zero entry
  - read enables with hold
  - read-during-write forwarding

Parameters:
- DATA_WIDTH, 16, width of each register and of every data port.
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH entries (derived, not overridable).
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero (writes dropped, reads return 0); when 0 entry 0 is an ordinary register.
- RESET_VALUE, 0, value loaded into every writable entry and both read outputs on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high; sampled on posedge clk.
- we  input  1  write enable.
- waddr  input  ADDR_WIDTH  write address.
- wdata  input  DATA_WIDTH  write data.
- re_a  input  1  read enable, port A.
- raddr_a  input  ADDR_WIDTH  read address, port A.
- rdata_a  output  DATA_WIDTH  registered read data, port A.
- re_b  input  1  read enable, port B.
- raddr_b  input  ADDR_WIDTH  read address, port B.
- rdata_b  output  DATA_WIDTH  registered read data, port B.

Behaviour:
- Single clock domain. No combinational path from any input to rdata_a/rdata_b; both outputs are flops.

Reset:
- On a posedge with rst=1:
  - every entry loads RESET_VALUE; entry 0 loads 0 when ZERO_REG=1.
  - rdata_a and rdata_b load RESET_VALUE.
- rst has priority: we, re_a and re_b are ignored that cycle.
- Reset mid-operation discards the in-flight write and both reads.
- Power-up (simulation time 0): all entries and outputs start at 0, matching the single-register initialisation.

Write:
- On a posedge with rst=0 and we=1, entry[waddr] <= wdata.
- If ZERO_REG=1 and waddr=0, the write is dropped silently. There is no error flag.

Read:
- Latency is 1 cycle. On a posedge with rst=0 and re_x=1, rdata_x <= value(raddr_x), where value is resolved in this priority order:
  1. ZERO_REG=1 and raddr_x=0 -> 0.
  2. An effective write this cycle (we=1, and not a dropped zero-register write) with waddr=raddr_x -> wdata (write-first forwarding).
  3. Otherwise -> entry[raddr_x] as it stood before the edge.
- When re_x=0, rdata_x holds its previous value, even if the addressed entry is written.

Concurrency:
- Ports A and B are fully independent; both may read the same address in the same cycle and both forward identically.
- A write and two reads in one cycle are legal.

Arithmetic and widths:
- No arithmetic; addresses are unsigned.
- All DEPTH addresses are valid; no out-of-range case exists.

Test Plan:
- Reset: write 0x1234 to entry 5, then assert rst for one cycle with we=1, re_a=1, re_b=1 -> after the edge, all entries and rdata_a/rdata_b = 0x0000. Reading entry 5 next cycle returns 0x0000.
- Basic write/read:
  - cycle n: we=1, waddr=3, wdata=0xBEEF.
  - cycle n+1: re_a=1, raddr_a=3 -> rdata_a=0xBEEF one cycle later.
  - re_a=0 thereafter -> rdata_a stays 0xBEEF while entry 3 is rewritten to 0x0001.
- Forwarding: entry 2 holds 0x1111. In one cycle drive we=1, waddr=2, wdata=0x2222, re_a=1, raddr_a=2, re_b=1, raddr_b=2 -> both rdata_a and rdata_b = 0x2222 after the edge.
- Zero register, ZERO_REG=1:
  - we=1, waddr=0, wdata=0xFFFF, re_a=1, raddr_a=0 in the same cycle -> rdata_a=0x0000.
  - Later read of entry 0 -> 0x0000.
- Zero register, ZERO_REG=0, same stimulus:
  - same-cycle read -> rdata_a=0xFFFF (forwarded).
  - later read -> 0xFFFF.
- Independence and sweep:
  - write entry i with 0xA000+i for i=0..7.
  - then read port A ascending and port B descending in the same cycles -> each returns its own address's value, 1-cycle latency, with entry 0 returning 0 when ZERO_REG=1.
